// File: rtl/gearbox_pkg.sv
// Shared types and defaults for the gearbox command path.
// Holds the conditioner FSM state enum and default timing constants.
package gearbox_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE_UP,
        ST_PULSE_DOWN,
        ST_LOCKOUT
    } gb_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 250;
    localparam int LOCKOUT_CYCLES_DEF  = 125;
    localparam int CNT_W_DEF           = 8;

    // True when a w-bit unsigned counter can hold every value up to max(a, b).
    function automatic bit cnt_fits(input int w, input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (w < 31) && ((1 << w) > m);
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer.
// Ports: clk, rst_n (async low), d_raw (async input), q_stable (debounced level).
module debounce_sync
    import gearbox_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_raw,
    output logic q_stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync1_d;
    logic             sync2_q;
    logic             sync2_d;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        sync1_d  = d_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        // A mismatch must persist for DEBOUNCE_CYCLES samples; the flip
        // happens on the last one, so the counter never needs to reach
        // DEBOUNCE_CYCLES itself.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign q_stable = stable_q;

endmodule

// File: rtl/gearbox_cmd_conditioner.sv
// Turns raw driver buttons into clean shift pulses and a debounced brake.
// Ports: clk, rst_n (async low), btn_up_raw, btn_down_raw, brake_raw in;
//        shift_up, shift_down (1-cycle pulses), brake (level), busy out.
module gearbox_cmd_conditioner
    import gearbox_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    input  logic brake_raw,
    output logic shift_up,
    output logic shift_down,
    output logic brake,
    output logic busy
);

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

    if (!cnt_fits(CNT_W, DEBOUNCE_CYCLES, LOCKOUT_CYCLES)) begin : g_bad_w
        $error("CNT_W too small for debounce/lockout counts");
    end

    logic up_stable;
    logic down_stable;
    logic brake_stable;

    debounce_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_up (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_raw   (btn_up_raw),
        .q_stable(up_stable)
    );

    debounce_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_down (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_raw   (btn_down_raw),
        .q_stable(down_stable)
    );

    debounce_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_brake (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_raw   (brake_raw),
        .q_stable(brake_stable)
    );

    logic             up_prev_q;
    logic             down_prev_q;
    logic             req_up;
    logic             req_down;
    gb_state_e        state_q;
    gb_state_e        state_d;
    logic [CNT_W-1:0] lock_cnt_q;
    logic [CNT_W-1:0] lock_cnt_d;
    logic             shift_up_q;
    logic             shift_up_d;
    logic             shift_down_q;
    logic             shift_down_d;
    logic             busy_q;
    logic             busy_d;

    // Edge history updates every cycle, even while locked out, so a held
    // button cannot fire once the lockout expires.
    assign req_up   = up_stable & ~up_prev_q & ~brake_stable;
    assign req_down = down_stable & ~down_prev_q;

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                // Simultaneous up and down is ambiguous: drop both.
                if (req_up ^ req_down) begin
                    state_d = req_up ? ST_PULSE_UP : ST_PULSE_DOWN;
                end
            end
            ST_PULSE_UP, ST_PULSE_DOWN: begin
                state_d    = ST_LOCKOUT;
                lock_cnt_d = LOCK_LAST;
            end
            ST_LOCKOUT: begin
                if (lock_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Outputs are decoded from the next state so they are registered
        // alongside it and line up with the state they describe.
        shift_up_d   = (state_d == ST_PULSE_UP);
        shift_down_d = (state_d == ST_PULSE_DOWN);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_prev_q    <= 1'b0;
            down_prev_q  <= 1'b0;
            state_q      <= ST_IDLE;
            lock_cnt_q   <= '0;
            shift_up_q   <= 1'b0;
            shift_down_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            up_prev_q    <= up_stable;
            down_prev_q  <= down_stable;
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            shift_up_q   <= shift_up_d;
            shift_down_q <= shift_down_d;
            busy_q       <= busy_d;
        end
    end

    assign shift_up   = shift_up_q;
    assign shift_down = shift_down_q;
    assign brake      = brake_stable;
    assign busy       = busy_q;

endmodule

// File: tb/tb_gearbox_cmd_conditioner.sv
// Self-checking bench for gearbox_cmd_conditioner with short timings.
// A behavioural model is compared every cycle, plus literal timing checks.
module tb_gearbox_cmd_conditioner;

    localparam int D = 4;
    localparam int L = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic up_raw;
    logic dn_raw;
    logic br_raw;
    logic shift_up;
    logic shift_down;
    logic brake;
    logic busy;

    always #20 clk = ~clk;

    gearbox_cmd_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .LOCKOUT_CYCLES (L),
        .CNT_W          (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_up_raw  (up_raw),
        .btn_down_raw(dn_raw),
        .brake_raw   (br_raw),
        .shift_up    (shift_up),
        .shift_down  (shift_down),
        .brake       (brake),
        .busy        (busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Model: raw -> 2-sample delay -> level accepted after D straight
    // disagreeing samples; a pulse claims the unit for 1+L cycles.
    bit m_sync [3][2];
    bit m_stab [3];
    int m_run  [3];
    bit m_prev_up;
    bit m_prev_dn;
    int m_left;
    bit m_su;
    bit m_sd;
    int cyc = 0;

    // Statistics gathered from DUT outputs for the literal checks.
    int up_pulses;
    int dn_pulses;
    int up_edge;
    int busy_cycles;
    int busy_first;

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_sync[c][0] = 1'b0;
            m_sync[c][1] = 1'b0;
            m_stab[c]    = 1'b0;
            m_run[c]     = 0;
        end
        m_prev_up = 1'b0;
        m_prev_dn = 1'b0;
        m_left    = 0;
        m_su      = 1'b0;
        m_sd      = 1'b0;
    endtask

    task automatic model_step();
        bit raw [3];
        bit rq_up;
        bit rq_dn;
        raw[0] = up_raw;
        raw[1] = dn_raw;
        raw[2] = br_raw;
        rq_up = m_stab[0] && !m_prev_up && !m_stab[2];
        rq_dn = m_stab[1] && !m_prev_dn;
        m_prev_up = m_stab[0];
        m_prev_dn = m_stab[1];
        for (int c = 0; c < 3; c++) begin
            if (m_sync[c][1] != m_stab[c]) begin
                m_run[c] = m_run[c] + 1;
                if (m_run[c] == D) begin
                    m_stab[c] = !m_stab[c];
                    m_run[c]  = 0;
                end
            end else begin
                m_run[c] = 0;
            end
            m_sync[c][1] = m_sync[c][0];
            m_sync[c][0] = raw[c];
        end
        m_su = 1'b0;
        m_sd = 1'b0;
        if (m_left == 0) begin
            if (rq_up != rq_dn) begin
                m_su   = rq_up;
                m_sd   = rq_dn;
                m_left = L + 1;
            end
        end else begin
            m_left = m_left - 1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (clk) cyc++;
            if (!rst_n) model_reset();
            else model_step();
            #1;
            check("shift_up", shift_up, m_su);
            check("shift_down", shift_down, m_sd);
            check("brake", brake, m_stab[2]);
            check("busy", busy, m_left > 0);
            if (shift_up === 1'b1) begin
                up_pulses++;
                up_edge = cyc;
            end
            if (shift_down === 1'b1) dn_pulses++;
            if (busy === 1'b1) begin
                busy_cycles++;
                if (busy_first < 0) busy_first = cyc;
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        up_pulses   = 0;
        dn_pulses   = 0;
        up_edge     = -1;
        busy_cycles = 0;
        busy_first  = -1;
    endtask

    int base;

    initial begin
        rst_n  = 1'b0;
        up_raw = 1'b0;
        dn_raw = 1'b0;
        br_raw = 1'b0;
        clr();
        wait_n(3);
        check("rst_shift_up", shift_up, 0);
        check("rst_shift_down", shift_down, 0);
        check("rst_brake", brake, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        wait_n(3);

        // 1: single press, held
        clr();
        up_raw = 1'b1;
        base = cyc;
        wait_n(20);
        check("t1_up_pulses", up_pulses, 1);
        check("t1_up_edge", up_edge - base, 7);
        check("t1_busy_first", busy_first - base, 7);
        check("t1_busy_cycles", busy_cycles, 4);
        clr();
        up_raw = 1'b0;
        wait_n(10);
        check("t1_release_pulses", up_pulses, 0);

        // 2: 3-cycle glitch, then 4-cycle press
        clr();
        dn_raw = 1'b1;
        wait_n(3);
        dn_raw = 1'b0;
        wait_n(12);
        check("t2_glitch_pulses", dn_pulses, 0);
        check("t2_glitch_busy", busy_cycles, 0);
        dn_raw = 1'b1;
        wait_n(4);
        dn_raw = 1'b0;
        wait_n(16);
        check("t2_press_pulses", dn_pulses, 1);

        // 3: brake blocks up, not down
        clr();
        br_raw = 1'b1;
        wait_n(10);
        check("t3_brake_level", brake, 1);
        up_raw = 1'b1;
        wait_n(12);
        up_raw = 1'b0;
        wait_n(8);
        check("t3_up_blocked", up_pulses, 0);
        dn_raw = 1'b1;
        wait_n(12);
        dn_raw = 1'b0;
        wait_n(8);
        check("t3_down_pulses", dn_pulses, 1);
        check("t3_brake_held", brake, 1);
        br_raw = 1'b0;
        wait_n(10);
        check("t3_brake_off", brake, 0);

        // 4: simultaneous up and down
        clr();
        up_raw = 1'b1;
        dn_raw = 1'b1;
        wait_n(14);
        check("t4_up_pulses", up_pulses, 0);
        check("t4_down_pulses", dn_pulses, 0);
        check("t4_busy_cycles", busy_cycles, 0);
        up_raw = 1'b0;
        dn_raw = 1'b0;
        wait_n(10);

        // 5: down edge lands inside lockout
        clr();
        up_raw = 1'b1;
        base = cyc;
        wait_n(2);
        dn_raw = 1'b1;
        wait_n(16);
        check("t5_up_pulses", up_pulses, 1);
        check("t5_down_pulses", dn_pulses, 0);
        check("t5_busy_cycles", busy_cycles, 4);
        check("t5_busy_idle", busy, 0);
        up_raw = 1'b0;
        dn_raw = 1'b0;
        wait_n(10);

        // 6: reset during PULSE_UP with up held
        clr();
        up_raw = 1'b1;
        base = cyc;
        wait_n(7);
        check("t6_pulse_live", shift_up, 1);
        rst_n = 1'b0;
        #2;
        check("t6_rst_shift_up", shift_up, 0);
        check("t6_rst_busy", busy, 0);
        wait_n(2);
        rst_n = 1'b1;
        clr();
        base = cyc;
        wait_n(16);
        check("t6_up_pulses", up_pulses, 1);
        check("t6_up_edge", up_edge - base, 7);
        up_raw = 1'b0;
        wait_n(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
